// File: rtl/nn_layer_sequencer.sv
// Fully-connected layer sequencer: drains inputs into a register file, then runs
// a signed MAC per neuron and pushes ReLU/saturated results to the output FIFO.
module nn_layer_sequencer #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned N_OUT    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned W_ADDR_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                in_empty_i,
    output logic                in_pop_o,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic                w_rd_o,
    output logic [W_ADDR_W-1:0] w_addr_o,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic                out_full_i,
    output logic                out_push_o,
    output logic [DATA_W-1:0]   out_data_o
);

    localparam int unsigned K_W    = $clog2(N_IN + 1);
    localparam int unsigned J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MAC,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [K_W-1:0]            i_q, i_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [J_W-1:0]            j_q, j_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         rf_q [N_IN];
    logic [DATA_W-1:0]         rf_d [N_IN];
    logic [DATA_W-1:0]         out_data_d;
    logic                      busy_d, done_d, w_rd_d;
    logic [W_ADDR_W-1:0]       w_addr_d;

    logic                      pop_c, push_c;
    logic signed [DATA_W-1:0]  x_sel;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   act_sum, act_shr;

    // FIFO handshakes must react to empty/full in the same cycle; abort suppresses both
    assign pop_c      = (state_q == S_FILL)  && !in_empty_i && !abort_i;
    assign push_c     = (state_q == S_WRITE) && !out_full_i && !abort_i;
    assign in_pop_o   = pop_c;
    assign out_push_o = push_c;

    // Weight data arriving at step k belongs to input k-1
    always_comb begin
        x_sel = '0;
        for (int unsigned n = 0; n < N_IN; n++) begin
            if (k_q == K_W'(n + 1)) x_sel = $signed(rf_q[n]);
        end
    end

    assign prod    = PROD_W'(x_sel) * PROD_W'($signed(w_data_i));
    assign act_sum = acc_q + ACC_W'($signed(w_data_i));
    assign act_shr = act_sum >>> SHIFT;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        rf_d       = rf_q;
        out_data_d = out_data_o;

        if (abort_i) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_FILL;
                        i_d     = '0;
                    end
                end
                S_FILL: begin
                    if (pop_c) begin
                        for (int unsigned n = 0; n < N_IN; n++) begin
                            if (i_q == K_W'(n)) rf_d[n] = in_data_i;
                        end
                        if (i_q == K_W'(N_IN - 1)) begin
                            state_d = S_MAC;
                            j_d     = '0;
                            k_d     = '0;
                            acc_d   = '0;
                        end else begin
                            i_d = i_q + K_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    if (k_q != '0) acc_d = acc_q + ACC_W'(prod);
                    if (k_q == K_W'(N_IN)) state_d = S_ACT;
                    else                   k_d = k_q + K_W'(1);
                end
                S_ACT: begin
                    if (act_shr[ACC_W-1])       out_data_d = '0;
                    else if (act_shr > OUT_MAX) out_data_d = {1'b0, {(DATA_W-1){1'b1}}};
                    else                        out_data_d = act_shr[DATA_W-1:0];
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (push_c) begin
                        if (j_q == J_W'(N_OUT - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_MAC;
                            j_d     = j_q + J_W'(1);
                            k_d     = '0;
                            acc_d   = '0;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        w_rd_d   = (state_d == S_MAC);
        w_addr_d = w_rd_d ? W_ADDR_W'(32'(j_d) * (N_IN + 1) + 32'(k_d)) : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            rf_q       <= '{default: '0};
            out_data_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            w_rd_o     <= 1'b0;
            w_addr_o   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            rf_q       <= rf_d;
            out_data_o <= out_data_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            w_rd_o     <= w_rd_d;
            w_addr_o   <= w_addr_d;
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomised/directed bench for nn_layer_sequencer against an arithmetic layer model
// with FIFO and weight-memory models.
module tb_nn_layer_sequencer;

    localparam int N_IN     = 4;
    localparam int N_OUT    = 2;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 24;
    localparam int SHIFT    = 0;
    localparam int W_ADDR_W = 8;
    localparam int OMAX     = 2 ** (DATA_W - 1) - 1;
    localparam int T_DONE   = 1 + N_IN + N_OUT * (N_IN + 3);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic                abort_i = 1'b0;
    logic                busy_o, done_o;
    logic                in_empty_i = 1'b1;
    logic                in_pop_o;
    logic [DATA_W-1:0]   in_data_i = '0;
    logic                w_rd_o;
    logic [W_ADDR_W-1:0] w_addr_o;
    logic [DATA_W-1:0]   w_data_i = '0;
    logic                out_full_i = 1'b0;
    logic                out_push_o;
    logic [DATA_W-1:0]   out_data_o;

    always #5 clk = ~clk;

    nn_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .ACC_W(ACC_W),
        .SHIFT(SHIFT), .W_ADDR_W(W_ADDR_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o),
        .in_empty_i(in_empty_i), .in_pop_o(in_pop_o), .in_data_i(in_data_i),
        .w_rd_o(w_rd_o), .w_addr_o(w_addr_o), .w_data_i(w_data_i),
        .out_full_i(out_full_i), .out_push_o(out_push_o), .out_data_o(out_data_o)
    );

    // Weight memory: one-cycle read latency, junk when not read
    logic [DATA_W-1:0] wmem [256];
    always @(posedge clk) w_data_i <= w_rd_o ? wmem[w_addr_o] : DATA_W'($urandom);

    int x [N_IN];
    int w [N_OUT][N_IN];
    int b [N_OUT];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, done_rel = -1;
    int pop_cnt = 0, push_cnt = 0, done_cnt = 0, base_pop = 0;
    int in_arr [1024];
    int in_rd = 0, in_wr = 0;
    int out_log [1024];
    int stall_after = -1, stall_len = 0, stall_rem = 0;
    int full_from = 0, full_len = 0;
    bit rnd_stall = 0, extra_start = 0, start_req = 0, abort_req = 0, hold_chk = 0;
    int hold_exp = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_neuron(input int j);
        int s;
        s = b[j];
        for (int k = 0; k < N_IN; k++) s += x[k] * w[j][k];
        s = s >>> SHIFT;
        if (s < 0) return 0;
        if (s > OMAX) return OMAX;
        return s;
    endfunction

    task automatic load_layer();
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_IN; k++) wmem[j*(N_IN+1)+k] = DATA_W'(w[j][k]);
            wmem[j*(N_IN+1)+N_IN] = DATA_W'(b[j]);
        end
        for (int k = 0; k < N_IN; k++) begin
            in_arr[in_wr] = x[k];
            in_wr++;
        end
    endtask

    // One clock: drive inputs on the falling edge, sample outputs just after
    task automatic tick();
        int rel;
        @(negedge clk);
        rel = cyc - start_cyc;
        in_empty_i = (in_rd >= in_wr) || (stall_rem > 0) || (rnd_stall && ($urandom_range(0, 2) == 0));
        if (stall_rem > 0) stall_rem--;
        in_data_i  = in_empty_i ? DATA_W'($urandom) : DATA_W'(in_arr[in_rd]);
        out_full_i = rnd_stall ? ($urandom_range(0, 2) == 0)
                               : (full_len > 0 && rel >= full_from && rel < full_from + full_len);
        start_i    = start_req || (extra_start && (rel == 2 || rel == 11));
        if (start_req) start_cyc = cyc;
        start_req  = 0;
        abort_i    = abort_req;
        abort_req  = 0;
        #1;
        if (!busy_o) chk("idle_quiet", {in_pop_o, out_push_o, w_rd_o, done_o}, 0);
        if (in_pop_o) begin
            chk("pop_not_empty", in_empty_i, 0);
            in_rd++;
            pop_cnt++;
            if (pop_cnt - base_pop == stall_after) stall_rem = stall_len;
        end
        if (out_full_i) chk("no_push_full", out_push_o, 0);
        if (out_full_i && hold_chk) chk("hold_data", $signed(out_data_o), hold_exp);
        if (out_push_o) begin
            out_log[push_cnt] = int'($signed(out_data_o));
            push_cnt++;
        end
        if (done_o) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
        end
        cyc++;
    endtask

    task automatic clear_cfg();
        stall_after = -1; stall_len = 0; full_len = 0;
        rnd_stall = 0; extra_start = 0; hold_chk = 0;
    endtask

    task automatic run_layer(input string name, input int exp_done);
        int bp, bd, t;
        bp = push_cnt; bd = done_cnt; t = 0;
        load_layer();
        base_pop  = pop_cnt;
        start_req = 1;
        do begin
            tick();
            t++;
        end while (done_cnt == bd && t < 400);
        repeat (4) tick();
        chk({name, "_done_cnt"}, done_cnt - bd, 1);
        chk({name, "_pushes"}, push_cnt - bp, N_OUT);
        chk({name, "_pops"}, pop_cnt - base_pop, N_IN);
        for (int j = 0; j < N_OUT; j++) chk({name, "_out"}, out_log[bp+j], ref_neuron(j));
        if (exp_done >= 0) chk({name, "_done_cycle"}, done_rel, exp_done);
        clear_cfg();
    endtask

    task automatic set_basic();
        x = '{1, 2, 3, 4};
        w[0] = '{1, 1, 1, 1};  b[0] = 0;
        w[1] = '{-1, -1, -1, -1}; b[1] = 0;
    endtask

    task automatic run_abort(input string name, input int at, input int exp_push);
        int bp, bd;
        bp = push_cnt; bd = done_cnt;
        set_basic();
        load_layer();
        base_pop  = pop_cnt;
        start_req = 1;
        tick();
        repeat (at - 1) tick();
        abort_req = 1;
        tick();
        tick();
        chk({name, "_busy_after"}, busy_o, 0);
        chk({name, "_rd_after"}, w_rd_o, 0);
        repeat (30) tick();
        chk({name, "_pushes"}, push_cnt - bp, exp_push);
        chk({name, "_no_done"}, done_cnt - bd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        foreach (wmem[a]) wmem[a] = '0;
        foreach (out_log[a]) out_log[a] = -999;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pop", in_pop_o, 0);
        chk("rst_push", out_push_o, 0);
        chk("rst_rd", w_rd_o, 0);
        chk("rst_addr", w_addr_o, 0);
        chk("rst_data", out_data_o, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        set_basic();
        run_layer("t1", T_DONE);
        chk("t1_out0_val", out_log[push_cnt-2], 10);
        chk("t1_out1_val", out_log[push_cnt-1], 0);

        x = '{100, 100, 0, 0};
        w[0] = '{1, 1, 0, 0}; b[0] = 0;
        w[1] = '{0, 0, 0, 0}; b[1] = 7;
        run_layer("t2", T_DONE);
        chk("t2_sat_val", out_log[push_cnt-2], 127);
        chk("t2_bias_val", out_log[push_cnt-1], 7);
        b[1] = -5;
        run_layer("t2n", T_DONE);
        chk("t2_negbias_val", out_log[push_cnt-1], 0);

        set_basic();
        stall_after = 2; stall_len = 3;
        run_layer("t3", T_DONE + 3);

        set_basic();
        full_from = 1 + N_IN + N_IN + 2; full_len = 5;
        hold_chk = 1; hold_exp = 10;
        run_layer("t4", T_DONE + 5);

        set_basic();
        extra_start = 1;
        run_layer("t6", T_DONE);

        run_abort("t5_mac", 1 + N_IN + (N_IN + 3) + 1, 1);
        run_abort("t5_write", 1 + N_IN + N_IN + 2, 0);

        set_basic();
        load_layer();
        start_req = 1;
        repeat (3) tick();
        chk("t5r_pre_pop", in_pop_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t5r_busy", busy_o, 0);
        chk("t5r_pop", in_pop_o, 0);
        chk("t5r_push", out_push_o, 0);
        chk("t5r_rd", w_rd_o, 0);
        chk("t5r_done", done_o, 0);
        chk("t5r_data", out_data_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_rd = in_wr;
        repeat (2) tick();
        set_basic();
        run_layer("t5r_again", T_DONE);

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N_IN; k++) begin
                x[k] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
                for (int j = 0; j < N_OUT; j++)
                    w[j][k] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
            end
            for (int j = 0; j < N_OUT; j++) b[j] = int'($urandom_range(0, 255)) - 128;
            rnd_stall = (r >= 12);
            run_layer("rnd", (r >= 12) ? -1 : T_DONE);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
